// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU operand-entry sequencer
package alu_seq_pkg;

    localparam int A_W    = 4;
    localparam int B_W    = 2;
    localparam int SEL_W  = 2;
    localparam int FLAG_W = 4;

    localparam logic [SEL_W-1:0] OP_MUL = 2'b00;
    localparam logic [SEL_W-1:0] OP_SUB = 2'b01;
    localparam logic [SEL_W-1:0] OP_AND = 2'b10;
    localparam logic [SEL_W-1:0] OP_XOR = 2'b11;

    typedef enum logic [2:0] {
        S_LOAD_A   = 3'd0,
        S_LOAD_B   = 3'd1,
        S_LOAD_SEL = 3'd2,
        S_EXEC     = 3'd3,
        S_SHOW     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, level debouncer and registered rising-edge press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             btn_s;
    logic             btn_db;
    logic [CNT_W-1:0] cnt;

    // press is raised on the same edge btn_db is accepted high, so it lags btn_db by nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            btn_s  <= 1'b0;
            btn_db <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
            press <= 1'b0;
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                btn_db <= btn_s;
                cnt    <= '0;
                press  <= btn_s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_input_seq.sv
// rtl/alu_input_seq.sv - walks the user through loading A, B and op select, then captures the ALU result
module alu_input_seq
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        sw,
    input  logic              btn,
    output logic [A_W-1:0]    alu_a,
    output logic [B_W-1:0]    alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [A_W-1:0]    alu_y,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic [A_W-1:0]    res_y,
    output logic [FLAG_W-1:0] res_flags,
    output logic              res_valid,
    output logic [2:0]        state_o
);

    logic       press;
    seq_state_t state_q;
    seq_state_t state_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn),
        .press  (press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD_A:   if (press) state_d = S_LOAD_B;
            S_LOAD_B:   if (press) state_d = S_LOAD_SEL;
            S_LOAD_SEL: if (press) state_d = S_EXEC;
            S_EXEC:     state_d = S_SHOW;
            S_SHOW:     if (press) state_d = S_LOAD_A;
            default:    state_d = S_LOAD_A;
        endcase
    end

    // Operands are written only in load states, so they never change under a valid result
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= OP_MUL;
            res_y     <= '0;
            res_flags <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD_A:   if (press) alu_a   <= sw;
                S_LOAD_B:   if (press) alu_b   <= sw[B_W-1:0];
                S_LOAD_SEL: if (press) alu_sel <= sw[SEL_W-1:0];
                S_EXEC: begin
                    res_y     <= alu_y;
                    res_flags <= {alu_z, alu_n, alu_c, alu_v};
                    res_valid <= 1'b1;
                end
                S_SHOW:     if (press) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_alu_input_seq.sv
// tb/tb_alu_input_seq.sv - self-checking bench for alu_input_seq with a behavioural ALU and result scoreboard
module tb_alu_input_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_y;
    logic       alu_z, alu_n, alu_c, alu_v;
    logic [3:0] res_y;
    logic [3:0] res_flags;
    logic       res_valid;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_input_seq #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btn      (btn),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_y    (alu_y),
        .alu_z    (alu_z),
        .alu_n    (alu_n),
        .alu_c    (alu_c),
        .alu_v    (alu_v),
        .res_y    (res_y),
        .res_flags(res_flags),
        .res_valid(res_valid),
        .state_o  (state_o)
    );

    // Returns {Y[3:0], Z, N, C, V}
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [1:0] b, input logic [1:0] sel);
        logic [5:0] p;
        logic [4:0] d;
        logic [3:0] y;
        logic       c;
        logic       v;
        p = 6'(a) * 6'(b);
        d = {1'b0, a} + {1'b0, ~{2'b00, b}} + 5'd1;
        case (sel)
            2'b00:   begin y = p[3:0]; c = |p[5:4]; v = 1'b0; end
            2'b01:   begin y = d[3:0]; c = d[4];    v = a[3] & ~d[3]; end
            2'b10:   begin y = a & {2'b00, b}; c = 1'b0; v = 1'b0; end
            default: begin y = a ^ {2'b00, b}; c = 1'b0; v = 1'b0; end
        endcase
        return {y, (y == 4'd0), y[3], c, v};
    endfunction

    assign {alu_y, alu_z, alu_n, alu_c, alu_v} = alu_model(alu_a, alu_b, alu_sel);

    task automatic reset_dut();
        rst = 1'b1;
        btn = 1'b0;
        sw  = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_btn(input logic [3:0] val);
        logic [2:0] start;
        bit         seen;
        sw = val;
        @(negedge clk);
        start = state_o;
        btn   = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (state_o !== start) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL press_advance: state_o=%0d still, required change from %0d", state_o, start);
        end
    endtask

    task automatic release_btn();
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_result(input string name);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: result appeared with no expected entry", name);
        end else begin
            exp = exp_q.pop_front();
            if ({res_y, res_flags} !== exp) begin
                errors++;
                $display("FAIL %s_result: res_y=%b res_flags=%b required res_y=%b res_flags=%b",
                         name, res_y, res_flags, exp[7:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({alu_a, alu_b, alu_sel, res_y, res_flags, res_valid, state_o} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: a=%h b=%h sel=%h y=%h f=%h v=%b st=%0d required all zero",
                     alu_a, alu_b, alu_sel, res_y, res_flags, res_valid, state_o);
        end
        checks++;
        if (dut.u_db.press !== 1'b0) begin
            errors++;
            $display("FAIL reset_press: press=%b required 0", dut.u_db.press);
        end
    endtask

    task automatic test_press_timing();
        reset_dut();
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (dut.u_db.press !== (i == 5)) begin
                errors++;
                $display("FAIL press_timing[%0d]: press=%b required %b", i, dut.u_db.press, (i == 5));
            end
        end
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL press_state: state_o=%0d required 1", state_o);
        end
        release_btn();
    endtask

    task automatic test_bounce();
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            btn = (i < 10) ? ~i[0] : 1'b0;
            @(negedge clk);
            checks++;
            if (dut.u_db.press !== 1'b0) begin
                errors++;
                $display("FAIL bounce_press[%0d]: press=%b required 0", i, dut.u_db.press);
            end
        end
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL bounce_state: state_o=%0d required 0", state_o);
        end
    endtask

    task automatic test_sub();
        reset_dut();
        exp_q.push_back({4'b0011, 4'b0010});
        press_btn(4'b0110);
        checks++;
        if (alu_a !== 4'b0110 || state_o !== 3'd1) begin
            errors++;
            $display("FAIL sub_load_a: alu_a=%b state_o=%0d required 0110 and 1", alu_a, state_o);
        end
        release_btn();
        press_btn(4'b0011);
        checks++;
        if (alu_b !== 2'b11 || state_o !== 3'd2) begin
            errors++;
            $display("FAIL sub_load_b: alu_b=%b state_o=%0d required 11 and 2", alu_b, state_o);
        end
        release_btn();
        press_btn(4'b0001);
        checks++;
        if (alu_sel !== 2'b01 || state_o !== 3'd3 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_exec: sel=%b state_o=%0d valid=%b required 01, 3, 0", alu_sel, state_o, res_valid);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 3'd4 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL sub_show: state_o=%0d valid=%b required 4 and 1", state_o, res_valid);
        end
        check_result("sub");
        release_btn();
    endtask

    task automatic test_mul_show();
        reset_dut();
        exp_q.push_back({4'b0000, 4'b1010});
        press_btn(4'b1000);
        release_btn();
        press_btn(4'b0010);
        release_btn();
        press_btn(4'b0000);
        @(negedge clk);
        check_result("mul");
        checks++;
        if (state_o !== 3'd4 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL mul_show: state_o=%0d valid=%b required 4 and 1", state_o, res_valid);
        end
        release_btn();
        checks++;
        if (state_o !== 3'd4 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL mul_hold: state_o=%0d valid=%b required 4 and 1", state_o, res_valid);
        end
        press_btn(4'b1111);
        checks++;
        if (state_o !== 3'd0 || res_valid !== 1'b0 || alu_a !== 4'b1000) begin
            errors++;
            $display("FAIL mul_leave: state_o=%0d valid=%b alu_a=%b required 0, 0, 1000", state_o, res_valid, alu_a);
        end
        release_btn();
    endtask

    task automatic test_rst_mid();
        reset_dut();
        press_btn(4'b1111);
        release_btn();
        press_btn(4'b0010);
        release_btn();
        checks++;
        if (state_o !== 3'd2 || alu_a !== 4'b1111) begin
            errors++;
            $display("FAIL rst_mid_setup: state_o=%0d alu_a=%b required 2 and 1111", state_o, alu_a);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_sel, res_y, res_flags, res_valid, state_o} !== 22'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: a=%h b=%h sel=%h y=%h f=%h v=%b st=%0d required all zero",
                     alu_a, alu_b, alu_sel, res_y, res_flags, res_valid, state_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [1:0] b;
        logic [1:0] s;
        for (int n = 0; n < 3; n++) begin
            reset_dut();
            a = 4'($urandom_range(0, 15));
            b = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            exp_q.push_back(alu_model(a, b, s));
            press_btn(a);
            release_btn();
            press_btn({2'b00, b});
            release_btn();
            press_btn({2'b00, s});
            @(negedge clk);
            check_result("random");
            release_btn();
        end
    endtask

    task automatic test_exec_ignore();
        reset_dut();
        exp_q.push_back({4'b0001, 4'b0000});
        press_btn(4'b0101);
        release_btn();
        press_btn(4'b0001);
        release_btn();
        press_btn(4'b0010);
        force dut.press = 1'b1;
        @(negedge clk);
        checks++;
        if (state_o !== 3'd4 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL exec_ignore: state_o=%0d valid=%b required 4 and 1", state_o, res_valid);
        end
        release dut.press;
        check_result("exec");
        btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press_timing();
        test_bounce();
        test_sub();
        test_mul_show();
        test_rst_mid();
        test_random();
        test_exec_ignore();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
